button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//   Conditions the four raw mole-hit buttons ahead of the anticheat stage.
//   Per button: 2-FF synchroniser, debouncer, press/release edge pulses.
//   btn_lvl feeds the anticheat inputs i1..i4.
//   A one-deep press-event buffer with a valid/ready handshake feeds the hit/score logic.
// PARAMETERS
//   DB_CYCLES  16  consecutive stable cycles needed before btn_lvl changes; legal range 2..31
//   CNT_W      5   debounce counter width; must hold DB_CYCLES
// PORTS
//   clk          in   1  system clock; all logic on posedge
//   rst_n        in   1  synchronous reset, active-low
//   btn_raw      in   4  raw buttons, asynchronous, active-high (bit0 = button 1)
//   en           in   1  1 = press events may be captured into the buffer
//   btn_lvl      out  4  debounced button levels, to anticheat i1..i4
//   btn_press    out  4  1-cycle pulse per button on debounced 0->1
//   btn_release  out  4  1-cycle pulse per button on debounced 1->0
//   press_valid  out  1  buffered press event available
//   press_idx    out  2  index of buffered press; lowest index wins
//   press_multi  out  1  >1 button pressed in the capture cycle (anticheat hint)
//   press_ready  in   1  consumer accepts the event
//   ovf          out  1  sticky: a press was lost because the buffer was full
//   clr_ovf      in   1  clears ovf
// BEHAVIOUR
//   Reset (rst_n=0 at a posedge)
//     - Sync flops, counters, btn_lvl, pulses, press_valid, press_idx, press_multi, ovf all go to 0.
//     - Applies mid-debounce or mid-handshake; any pending event is discarded.
//   Synchroniser
//     - s1 <= btn_raw; s2 <= s1. Only s2 is used downstream.
//   Debounce, per button b
//     - If s2[b] == btn_lvl[b]: cnt <= 0.
//     - Else if cnt == DB_CYCLES-1: btn_lvl[b] toggles and cnt <= 0.
//     - Else: cnt <= cnt+1.
//     - A glitch shorter than DB_CYCLES cycles never changes btn_lvl.
//     - Latency from the first posedge sampling a stable new raw value to the btn_lvl change is DB_CYCLES+2 cycles.
//   Edge pulses
//     - btn_press[b] and btn_release[b] are registered.
//     - Each asserts in the same cycle btn_lvl[b] shows the new value, for exactly 1 cycle.
//     - Release pulses do not create buffer events.
//   Event buffer (one entry)
//     - cap = en & |btn_press.
//     - Transfer = press_valid & press_ready.
//     - Empty, or transfer this cycle, with cap:
//         * press_valid <= 1.
//         * press_idx <= lowest set bit of btn_press.
//         * press_multi <= (popcount(btn_press) > 1).
//     - Transfer without cap: press_valid <= 0; press_idx and press_multi hold.
//     - Full, no transfer, cap: entry holds unchanged and ovf <= 1.
//     - press_idx and press_multi stay stable while press_valid=1 and not transferred.
//     - press_valid never drops without a transfer, except on reset.
//     - en=0 blocks capture only; debounce and pulses continue, pending entry stays.
//   ovf
//     - Set has priority over clr_ovf in the same cycle.
//     - Otherwise clr_ovf=1 clears it next cycle.
// TESTING
//   T1
//     - Stimulus: DB_CYCLES=16; raise btn_raw[2] and hold.
//     - Response: btn_lvl[2]=1 and btn_press[2]=1 exactly 18 cycles later; press_valid=1, press_idx=2 on the next cycle.
//   T2
//     - Stimulus: 10-cycle high glitch on btn_raw[0].
//     - Response: btn_lvl stays 0; no press, release or valid.
//   T3
//     - Stimulus: btn_raw[1] and btn_raw[3] rise on the same clock.
//     - Response: one event with press_idx=1, press_multi=1; btn_lvl=4'b1010 presented to anticheat.
//   T4
//     - Stimulus: press_ready=0 with an event pending; then press button 0.
//     - Response: ovf=1; press_idx unchanged; clr_ovf then clears ovf.
//   T5
//     - Stimulus: press_ready=1 in the same cycle a new press pulse arrives.
//     - Response: press_valid stays 1 and the new idx is loaded; ovf stays 0.
//   T6
//     - Stimulus: rst_n=0 for 1 cycle mid-debounce, with an event pending.
//     - Response: all outputs 0 next cycle; debounce restarts from cnt=0.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner
//   Conditions the four raw mole-hit buttons ahead of the anticheat stage.
//   Each button has a 2-FF synchroniser, a debouncer and registered
//   press/release pulses. A one-entry press-event buffer with a valid/ready
//   handshake feeds the hit/score logic.
// Ports
//   clk          system clock, all logic on posedge
//   rst_n        synchronous reset, active-low
//   btn_raw[4]   raw asynchronous buttons, active-high (bit0 = button 1)
//   en           1 = press events may be captured into the buffer
//   btn_lvl[4]   debounced levels, to anticheat i1..i4
//   btn_press[4] 1-cycle pulse on debounced 0->1
//   btn_release  1-cycle pulse on debounced 1->0
//   press_valid  buffered press event available
//   press_idx[2] index of buffered press, lowest index wins
//   press_multi  more than one button pressed in the capture cycle
//   press_ready  consumer accepts the buffered event
//   ovf          sticky: a press was lost because the buffer was full
//   clr_ovf      clears ovf
module button_conditioner #(
    parameter int unsigned DB_CYCLES = 16,
    parameter int unsigned CNT_W     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       btn_raw,
    input  logic             en,
    output logic [3:0]       btn_lvl,
    output logic [3:0]       btn_press,
    output logic [3:0]       btn_release,
    output logic             press_valid,
    output logic [1:0]       press_idx,
    output logic             press_multi,
    input  logic             press_ready,
    output logic             ovf,
    input  logic             clr_ovf
);

    localparam int unsigned NB    = 4;
    localparam int unsigned IDX_W = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [NB-1:0]    s1;
    logic [NB-1:0]    s2;
    logic [CNT_W-1:0] cnt [NB];
    logic [NB-1:0]    flip;
    logic             cap;
    logic             xfer;
    logic             load;
    logic             lost;
    logic [IDX_W-1:0] first_idx;
    logic             multi;

    // Lowest set bit of a press vector; 0 when empty (never used then).
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NB-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Two-flop synchroniser; only s2 is used downstream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // A button flips once its synchronised value has disagreed with the
    // debounced level for DB_CYCLES consecutive samples.
    always_comb begin
        flip = '0;
        for (int b = 0; b < NB; b++) begin
            flip[b] = (s2[b] != btn_lvl[b]) && (cnt[b] == CNT_LAST);
        end
    end

    // Debounce counters, levels and edge pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < NB; b++) begin
                cnt[b] <= '0;
            end
            btn_lvl     <= '0;
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (s2[b] == btn_lvl[b] || flip[b]) begin
                    cnt[b] <= '0;
                end else begin
                    cnt[b] <= cnt[b] + CNT_W'(1);
                end
            end
            btn_lvl     <= btn_lvl ^ flip;
            btn_press   <= flip & ~btn_lvl;
            btn_release <= flip & btn_lvl;
        end
    end

    // Event buffer control: load when empty or draining, lose when full and stalled.
    always_comb begin
        cap       = en && (btn_press != '0);
        xfer      = press_valid && press_ready;
        load      = cap && (!press_valid || xfer);
        lost      = cap && press_valid && !press_ready;
        first_idx = lowest_set(btn_press);
        multi     = (btn_press & (btn_press - NB'(1))) != '0;
    end

    // One-entry press buffer; idx/multi only change on load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            press_valid <= 1'b0;
            press_idx   <= '0;
            press_multi <= 1'b0;
        end else if (load) begin
            press_valid <= 1'b1;
            press_idx   <= first_idx;
            press_multi <= multi;
        end else if (xfer) begin
            press_valid <= 1'b0;
        end
    end

    // Sticky overflow; a new loss wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (lost) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: hand-written corner sequences followed by a
// table of press patterns whose expected events go through a scoreboard queue.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn_raw;
    logic       en;
    logic [3:0] btn_lvl;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic       press_valid;
    logic [1:0] press_idx;
    logic       press_multi;
    logic       press_ready;
    logic       ovf;
    logic       clr_ovf;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    logic mon_en = 1'b0;

    typedef struct {
        logic [1:0] idx;
        logic       multi;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [3:0] mask;
        logic       en;
        logic       ev;
        logic [1:0] idx;
        logic       multi;
    } vec_t;
    vec_t vecs[6];

    button_conditioner #(.DB_CYCLES(16), .CNT_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .en          (en),
        .btn_lvl     (btn_lvl),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .press_valid (press_valid),
        .press_idx   (press_idx),
        .press_multi (press_multi),
        .press_ready (press_ready),
        .ovf         (ovf),
        .clr_ovf     (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: every accepted event must match the oldest expectation.
    always @(negedge clk) begin
        if (mon_en && press_valid && press_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_event", {30'd0, press_idx}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                pops++;
                check("sb_idx", {30'd0, press_idx}, {30'd0, e.idx});
                check("sb_multi", {31'd0, press_multi}, {31'd0, e.multi});
            end
        end
    end

    initial begin
        vecs[0] = '{mask: 4'b0010, en: 1'b1, ev: 1'b1, idx: 2'd1, multi: 1'b0};
        vecs[1] = '{mask: 4'b1010, en: 1'b1, ev: 1'b1, idx: 2'd1, multi: 1'b1};
        vecs[2] = '{mask: 4'b1000, en: 1'b1, ev: 1'b1, idx: 2'd3, multi: 1'b0};
        vecs[3] = '{mask: 4'b1111, en: 1'b1, ev: 1'b1, idx: 2'd0, multi: 1'b1};
        vecs[4] = '{mask: 4'b0100, en: 1'b0, ev: 1'b0, idx: 2'd0, multi: 1'b0};
        vecs[5] = '{mask: 4'b1100, en: 1'b1, ev: 1'b1, idx: 2'd2, multi: 1'b1};

        rst_n       = 1'b0;
        btn_raw     = 4'b0000;
        en          = 1'b1;
        press_ready = 1'b0;
        clr_ovf     = 1'b0;
        tick(2);
        check("reset_outputs",
              {18'd0, btn_lvl, btn_press, btn_release, press_valid, press_idx, press_multi, ovf},
              32'd0);
        rst_n = 1'b1;

        // Glitch of 10 cycles on button 0 must not reach btn_lvl.
        btn_raw = 4'b0001;
        tick(10);
        btn_raw = 4'b0000;
        for (int i = 0; i < 25; i++) begin
            tick(1);
            check("glitch_quiet", {19'd0, btn_lvl, btn_press, btn_release, press_valid}, 32'd0);
        end

        // Press button 2: level changes exactly 18 cycles after the raw rise.
        btn_raw = 4'b0100;
        tick(17);
        check("t1_lvl_early", {28'd0, btn_lvl}, 32'd0);
        tick(1);
        check("t1_lvl", {28'd0, btn_lvl}, 32'h4);
        check("t1_press", {28'd0, btn_press}, 32'h4);
        tick(1);
        check("t1_press_gone", {28'd0, btn_press}, 32'd0);
        check("t1_valid", {31'd0, press_valid}, 32'd1);
        check("t1_idx", {30'd0, press_idx}, 32'd2);

        // Full buffer, consumer stalled: new press is lost and flagged.
        btn_raw = 4'b0101;
        tick(18);
        check("t4_press", {28'd0, btn_press}, 32'h1);
        tick(1);
        check("t4_ovf", {31'd0, ovf}, 32'd1);
        check("t4_valid", {31'd0, press_valid}, 32'd1);
        check("t4_idx_held", {30'd0, press_idx}, 32'd2);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        check("t4_ovf_clr", {31'd0, ovf}, 32'd0);

        // Transfer and capture in the same cycle: entry reloads, no overflow.
        btn_raw = 4'b0111;
        tick(18);
        check("t5_press", {28'd0, btn_press}, 32'h2);
        press_ready = 1'b1;
        tick(1);
        check("t5_valid", {31'd0, press_valid}, 32'd1);
        check("t5_idx", {30'd0, press_idx}, 32'd1);
        check("t5_multi", {31'd0, press_multi}, 32'd0);
        check("t5_ovf", {31'd0, ovf}, 32'd0);
        tick(1);
        check("t5_drained", {31'd0, press_valid}, 32'd0);
        press_ready = 1'b0;

        // Release all: release pulses only, no new events.
        btn_raw = 4'b0000;
        tick(18);
        check("rel_pulse", {28'd0, btn_release}, 32'h7);
        check("rel_lvl", {28'd0, btn_lvl}, 32'd0);
        tick(1);
        check("rel_pulse_gone", {28'd0, btn_release}, 32'd0);
        check("rel_no_event", {31'd0, press_valid}, 32'd0);

        // Reset mid-debounce with an event pending.
        btn_raw = 4'b1000;
        tick(19);
        check("t6_pending", {29'd0, press_valid, press_idx}, 32'h7);
        btn_raw = 4'b1001;
        tick(8);
        rst_n = 1'b0;
        tick(1);
        check("t6_reset",
              {18'd0, btn_lvl, btn_press, btn_release, press_valid, press_idx, press_multi, ovf},
              32'd0);
        rst_n = 1'b1;
        tick(17);
        check("t6_restart_early", {28'd0, btn_lvl}, 32'd0);
        tick(1);
        check("t6_restart_lvl", {28'd0, btn_lvl}, 32'h9);
        check("t6_restart_press", {28'd0, btn_press}, 32'h9);
        tick(1);
        check("t6_event", {29'd0, press_valid, press_idx}, 32'h4);
        check("t6_multi", {31'd0, press_multi}, 32'd1);
        btn_raw     = 4'b0000;
        press_ready = 1'b1;
        tick(1);
        check("t6_drained", {31'd0, press_valid}, 32'd0);
        tick(20);
        check("t6_released", {28'd0, btn_lvl}, 32'd0);

        // Table of press patterns, events checked via the scoreboard.
        mon_en = 1'b1;
        for (int v = 0; v < 6; v++) begin
            en      = vecs[v].en;
            btn_raw = vecs[v].mask;
            if (vecs[v].ev) begin
                sb.push_back('{idx: vecs[v].idx, multi: vecs[v].multi});
            end
            tick(18);
            check("tbl_lvl", {28'd0, btn_lvl}, {28'd0, vecs[v].mask});
            check("tbl_press", {28'd0, btn_press}, {28'd0, vecs[v].mask});
            tick(3);
            btn_raw = 4'b0000;
            en      = 1'b1;
            tick(20);
            check("tbl_release_lvl", {28'd0, btn_lvl}, 32'd0);
        end
        mon_en = 1'b0;
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("sb_pops", 32'(pops), 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
